// File: rtl/varicode_stream_decoder.sv
// Serial PSK31 Varicode word decoder: bit accumulator, registered lookup, output FIFO.
// Define VARICODE_CTRL_EN to add LF (11101) and CR (11111) to the code table.
module varicode_stream_decoder #(
    parameter int MAX_LEN    = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(MAX_LEN + 2)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_unknown,
    output logic       err_overlong,
    output logic       fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LMAX  = CW'(MAX_LEN);
    localparam logic [CW-1:0] LMAX1 = CW'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        HUNT,
        CODE,
        ZERO,
        DISCARD,
        DISC_Z
    } state_t;

    // Codes for 0x20..0x7F, right-aligned; every code starts and ends with 1.
    localparam logic [9:0] VC [0:95] = '{
        10'b1,
        10'b111111111,
        10'b101011111,
        10'b111110101,
        10'b111011011,
        10'b1011010101,
        10'b1010111011,
        10'b101111111,
        10'b11111011,
        10'b11110111,
        10'b101101111,
        10'b111011111,
        10'b1110101,
        10'b110101,
        10'b1010111,
        10'b110101111,
        10'b10110111,
        10'b10111101,
        10'b11101101,
        10'b11111111,
        10'b101110111,
        10'b101011011,
        10'b101101011,
        10'b110101101,
        10'b110101011,
        10'b110110111,
        10'b11110101,
        10'b110111101,
        10'b111101101,
        10'b1010101,
        10'b111010111,
        10'b1010101111,
        10'b1010111101,
        10'b1111101,
        10'b11101011,
        10'b10101101,
        10'b10110101,
        10'b1110111,
        10'b11011011,
        10'b11111101,
        10'b101010101,
        10'b1111111,
        10'b111111101,
        10'b101111101,
        10'b11010111,
        10'b10111011,
        10'b11011101,
        10'b10101011,
        10'b11010101,
        10'b111011101,
        10'b10101111,
        10'b1101111,
        10'b1101101,
        10'b101010111,
        10'b110110101,
        10'b101011101,
        10'b101110101,
        10'b101111011,
        10'b1010101101,
        10'b111110111,
        10'b111101111,
        10'b111111011,
        10'b1010111111,
        10'b101101101,
        10'b1011011111,
        10'b1011,
        10'b1011111,
        10'b101111,
        10'b101101,
        10'b11,
        10'b111101,
        10'b1011011,
        10'b101011,
        10'b1101,
        10'b111101011,
        10'b10111111,
        10'b11011,
        10'b111011,
        10'b1111,
        10'b111,
        10'b111111,
        10'b110111111,
        10'b10101,
        10'b10111,
        10'b101,
        10'b110111,
        10'b1111011,
        10'b1101011,
        10'b11011111,
        10'b1011101,
        10'b111010101,
        10'b1010110111,
        10'b110111011,
        10'b1010110101,
        10'b1011010111,
        10'b1110110101
    };

    function automatic int vc_len(input logic [9:0] v);
        int n;
        n = 0;
        for (int j = 0; j < 10; j++) begin
            if (v[j]) n = j + 1;
        end
        return n;
    endfunction

    state_t               state, state_n;
    logic [MAX_LEN-1:0]   sr, sr_n;
    logic [CW-1:0]        len, len_n;
    logic                 done, ovl;

    logic                 lk_valid;
    logic [MAX_LEN-1:0]   lk_sr;
    logic [CW-1:0]        lk_len;
    logic [15:0]          lk_key;
    logic                 hit;
    logic [7:0]           hit_ch;
    logic                 push;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr, rnx;
    logic [AW:0]          count, keep;
    logic                 pop, full, wr;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        len_n   = len;
        done    = 1'b0;
        ovl     = 1'b0;
        if (!en) begin
            state_n = HUNT;
            sr_n    = '0;
            len_n   = '0;
        end else if (bit_valid) begin
            unique case (state)
                HUNT: begin
                    if (bit_in) begin
                        sr_n    = MAX_LEN'(1);
                        len_n   = CW'(1);
                        state_n = CODE;
                    end
                end
                CODE: begin
                    if (!bit_in) begin
                        state_n = ZERO;
                    end else if (len == LMAX) begin
                        ovl     = 1'b1;
                        sr_n    = '0;
                        len_n   = '0;
                        state_n = DISCARD;
                    end else begin
                        sr_n  = {sr[MAX_LEN-2:0], 1'b1};
                        len_n = len + CW'(1);
                    end
                end
                ZERO: begin
                    if (!bit_in) begin
                        done    = 1'b1;
                        sr_n    = '0;
                        len_n   = '0;
                        state_n = HUNT;
                    end else if (len >= LMAX1) begin
                        ovl     = 1'b1;
                        sr_n    = '0;
                        len_n   = '0;
                        state_n = DISCARD;
                    end else begin
                        sr_n    = {sr[MAX_LEN-3:0], 2'b01};
                        len_n   = len + CW'(2);
                        state_n = CODE;
                    end
                end
                DISCARD: begin
                    if (!bit_in) state_n = DISC_Z;
                end
                DISC_Z: begin
                    state_n = bit_in ? DISCARD : HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            sr           <= '0;
            len          <= '0;
            lk_valid     <= 1'b0;
            lk_sr        <= '0;
            lk_len       <= '0;
            err_unknown  <= 1'b0;
            err_overlong <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            len          <= len_n;
            lk_valid     <= done;
            lk_sr        <= sr;
            lk_len       <= len;
            err_unknown  <= lk_valid & ~hit;
            err_overlong <= ovl;
        end
    end

    assign lk_key = 16'(lk_sr);

    always_comb begin
        hit    = 1'b0;
        hit_ch = 8'h00;
        for (int i = 0; i < 96; i++) begin
            if (int'(lk_len) == vc_len(VC[i]) && lk_key == 16'(VC[i])) begin
                hit    = 1'b1;
                hit_ch = 8'(32 + i);
            end
        end
`ifdef VARICODE_CTRL_EN
        if (lk_len == CW'(5) && lk_key == 16'b11101) begin
            hit    = 1'b1;
            hit_ch = 8'h0A;
        end
        if (lk_len == CW'(5) && lk_key == 16'b11111) begin
            hit    = 1'b1;
            hit_ch = 8'h0D;
        end
`endif
    end

    assign push = lk_valid & hit;

    // Head register shows only entries present before this edge, so a fresh
    // push becomes visible one cycle after it lands.
    assign pop  = out_valid & out_ready;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign wr   = push & (~full | pop);
    assign keep = count - (AW+1)'(pop);
    assign rnx  = rptr + AW'(pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= hit_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            fifo_ovf  <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            rptr  <= rnx;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            if (push & full & ~pop) fifo_ovf <= 1'b1;
            out_valid <= keep != '0;
            if (keep != '0) out_data <= mem[rnx];
        end
    end
endmodule

// File: doc/varicode_stream_decoder.md
Name: varicode_stream_decoder

Overview:
- Serial PSK31 Varicode word decoder. Sits between the bit slicer and the UART/character sink in the decode path.
- Accumulates demodulated bits, detects the "00" word separator, maps each word to ASCII, and queues characters in an output FIFO with a valid/ready interface.
- Successor to the purely combinational table lookup: parametrised word length and buffer depth, streaming FSM, error reporting and backpressure.

Parameters:
- MAX_LEN, 10, longest accepted code in bits, excluding separator; legal range 10..16.
- FIFO_DEPTH, 4, output character FIFO entries; power of two, at least 2.
- CW, $clog2(MAX_LEN+2), width of the internal bit-length counter (derived, not to be overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  decoder enable; low forces HUNT and clears the partial word.
- bit_in  in  1  demodulated bit; first received bit is the MSB of the code.
- bit_valid  in  1  bit_in is sampled on this cycle's rising edge.
- out_data  out  8  ASCII character at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts out_data; pop when out_valid && out_ready.
- err_unknown  out  1  one-cycle pulse: complete word not in table.
- err_overlong  out  1  one-cycle pulse: word exceeded MAX_LEN.
- fifo_ovf  out  1  sticky; a character was dropped because the FIFO was full. Cleared only by rst.

Behaviour:
- Reset: out_valid=0, out_data=0x00, err_unknown=0, err_overlong=0, fifo_ovf=0, FSM=HUNT, shift register=0, len=0, FIFO empty.
- Rising-edge sampling only; bits with bit_valid=0 are ignored and leave all state unchanged.
- FSM states:
  - HUNT: 0 ignored. 1 sets sr=1, len=1, goes to CODE.
  - CODE (last bit 1): 1 appends, len+1. 0 goes to ZERO.
  - ZERO (one pending 0): 1 appends "01", len+2, goes to CODE. 0 completes the word: issue lookup, go to HUNT.
  - DISCARD: wait for "00", then HUNT. No lookup.
- Overlong: if an append would make len>MAX_LEN, pulse err_overlong on the following cycle and go to DISCARD. The separator ends the discard.
- Lookup table: standard PSK31 Varicode for 0x20..0x7F, 96 entries, compared on full value and length.
- Lookup stage is registered:
  - Word completes at edge k.
  - Table hit: push at edge k+1. out_valid is high after edge k+2 if the FIFO was empty.
  - Table miss: err_unknown high for the cycle after edge k+1, no push.
- FIFO: out_data is the registered head.
  - Push when full with no pop in the same cycle: character dropped, fifo_ovf set.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the push lands; out_valid rises next cycle.
- en=0: FSM goes to HUNT and sr/len clear on the next edge. A lookup already registered still completes. FIFO and out_* continue to operate.
- Back-to-back words: "...1 0 0 1..." is legal. The next word's first 1 may arrive on the cycle after the separator.
- rst mid-word or mid-FIFO: everything returns to reset values; partial and queued characters are lost.

Optional Feature:
- VARICODE_CTRL_EN
  - Defined: table adds LF 0x0A (code 11101) and CR 0x0D (code 11111).
  - Undefined: those codes are table misses and raise err_unknown.

Test Plan:
- rst, en=1, bits 1,1,0,0 -> out_valid high 2 edges after the final 0; out_data=0x65; pop with out_ready=1 -> out_valid=0.
- Stream 1011 00 101 00 1 00, out_ready=1 -> characters 0x61, 0x74, 0x20 in order; no error pulses.
- Eleven 1s then 0,0 (MAX_LEN=10) -> err_overlong one pulse, no push; following 11 00 -> 0x65.
- Word 1011011011 then 00 -> err_unknown one pulse, FIFO unchanged. With VARICODE_CTRL_EN, 11101 00 -> 0x0A; without it, err_unknown.
- out_ready=0, send five "11 00" words (FIFO_DEPTH=4) -> four entries of 0x65, fifo_ovf=1. Drain -> 4 pops, fifo_ovf stays 1.
- Send 1,0,1, assert rst one cycle, then 1,1,0,0 -> only 0x65 output. Repeat with en=0 pulse instead of rst -> same result, fifo_ovf unaffected.
